// File: rtl/ice_uart_rx.sv
// ICE debug link UART receiver: 16x oversampled 8N1 deframer feeding a
// first-word-fall-through byte FIFO read by the command decoder.
module ice_uart_rx #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       serial_in,
    input  logic       en_16_x_baud,
    input  logic       read_buffer,
    input  logic       reset_buffer,
    output logic [7:0] data_out,
    output logic       buffer_data_present,
    output logic       buffer_half_full,
    output logic       buffer_full,
    output logic       framing_error,
    output logic       overrun
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic rx_m;
    logic rx_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= serial_in;
            rx_s <= rx_m;
        end
    end

    // ------------------------------------------------------------------
    // Deframer
    // ------------------------------------------------------------------
    state_t     state;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       push_req;

    // A good stop bit completes the byte on this very edge.
    assign push_req = en_16_x_baud && (state == STOP) && (cnt == 4'd15) && rx_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bit_idx       <= 3'd0;
            shift         <= 8'h00;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            if (en_16_x_baud) begin
                cnt <= cnt + 4'd1;
                unique case (state)
                    IDLE: begin
                        cnt <= 4'd0;
                        if (!rx_s) state <= START;
                    end
                    START: begin
                        if (cnt == 4'd7) begin
                            cnt     <= 4'd0;
                            bit_idx <= 3'd0;
                            state   <= rx_s ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (cnt == 4'd15) begin
                            shift   <= {rx_s, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                cnt   <= 4'd0;
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (cnt == 4'd15) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                framing_error <= 1'b1;
                                state         <= BRK;
                            end
                        end
                    end
                    BRK: begin
                        // Wait out a held-low line before hunting for a start bit.
                        cnt <= 4'd0;
                        if (rx_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [7:0]    mem [DEPTH];
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));
    assign pop   = read_buffer && !empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign push  = push_req && (!full || pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop && !reset_buffer;
            if (reset_buffer) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !reset_buffer) mem[wr_ptr[DEPTH_LOG2-1:0]] <= shift;
    end

    assign buffer_data_present = !empty;
    assign buffer_half_full    = (count >= PW'(DEPTH / 2));
    assign buffer_full         = full;
    assign data_out            = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: tb/tb_ice_uart_rx.sv
// Directed bench for ice_uart_rx: frames are driven cycle-exactly with a
// baud strobe every 4 CLK, so the stop-bit sample edge is cycle 612 of a frame.
module tb_ice_uart_rx;
    logic       CLK;
    logic       RST;
    logic       serial_in;
    logic       en_16_x_baud;
    logic       read_buffer;
    logic       reset_buffer;
    logic [7:0] data_out;
    logic       buffer_data_present;
    logic       buffer_half_full;
    logic       buffer_full;
    logic       framing_error;
    logic       overrun;

    int         total;
    int         bad;
    int         fe_cnt;
    int         ov_cnt;
    logic [1:0] div;

    localparam int PUSH_CYC = 612;

    ice_uart_rx #(.DEPTH_LOG2(4)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .serial_in           (serial_in),
        .en_16_x_baud        (en_16_x_baud),
        .read_buffer         (read_buffer),
        .reset_buffer        (reset_buffer),
        .data_out            (data_out),
        .buffer_data_present (buffer_data_present),
        .buffer_half_full    (buffer_half_full),
        .buffer_full         (buffer_full),
        .framing_error       (framing_error),
        .overrun             (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        fe_cnt = 0;
        ov_cnt = 0;
    end

    always @(negedge CLK) begin
        if (framing_error === 1'b1) fe_cnt = fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt = ov_cnt + 1;
    end

    task automatic step();
        @(negedge CLK);
        div = div + 2'd1;
        en_16_x_baud = (div == 2'd0);
    endtask

    task automatic idle(input int ticks);
        repeat (4 * ticks) step();
    endtask

    task automatic align();
        do step(); while (!en_16_x_baud);
    endtask

    task automatic pop_one();
        read_buffer = 1'b1;
        step();
        read_buffer = 1'b0;
    endtask

    // Start bit, 8 data bits LSB first, then stop_ticks of stop_val.
    task automatic send_frame(input logic [7:0] b, input int stop_ticks, input logic stop_val,
                              input int pop_at, input int rb_at);
        int ncyc;
        ncyc = 4 * (144 + stop_ticks);
        align();
        for (int c = 0; c < ncyc; c++) begin
            int slot;
            if (c > 0) step();
            slot = (c / 4) / 16;
            if (slot == 0) serial_in = 1'b0;
            else if (slot <= 8) serial_in = b[slot-1];
            else serial_in = stop_val;
            read_buffer  = (c == pop_at);
            reset_buffer = (c == rb_at);
        end
        serial_in    = 1'b1;
        read_buffer  = 1'b0;
        reset_buffer = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 16, 1'b1, -1, -1);
        idle(2);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        serial_in = 1'b1;
        en_16_x_baud = 1'b0;
        read_buffer = 1'b0;
        reset_buffer = 1'b0;
        div = 2'd0;
        repeat (6) step();
        total++;
        if ({data_out, buffer_data_present, buffer_half_full, buffer_full, framing_error, overrun} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h p=%b h=%b f=%b fe=%b ov=%b want all 0",
                     data_out, buffer_data_present, buffer_half_full, buffer_full, framing_error, overrun);
        end
        RST = 1'b0;
        idle(4);
        total++;
        if (buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_present: got %b want 0", buffer_data_present);
        end
    endtask

    task automatic test_basic();
        send_byte(8'hA5);
        total++;
        if (buffer_data_present !== 1'b1 || data_out !== 8'hA5) begin
            bad++;
            $display("FAIL basic_a5: got p=%b data=%h want p=1 data=a5", buffer_data_present, data_out);
        end
        pop_one();
        total++;
        if (buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL basic_pop: got p=%b want 0", buffer_data_present);
        end
    endtask

    task automatic test_glitch();
        align();
        serial_in = 1'b0;
        repeat (16) step();
        serial_in = 1'b1;
        idle(40);
        total++;
        if (buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL glitch_no_push: got p=%b want 0", buffer_data_present);
        end
        send_byte(8'h3C);
        total++;
        if (buffer_data_present !== 1'b1 || data_out !== 8'h3C) begin
            bad++;
            $display("FAIL glitch_then_3c: got p=%b data=%h want p=1 data=3c", buffer_data_present, data_out);
        end
        pop_one();
    endtask

    task automatic test_framing();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'hFF, 20, 1'b0, -1, -1);
        idle(6);
        total++;
        if (fe_cnt - fe0 !== 1 || buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL framing_pulse: got pulses=%0d p=%b want pulses=1 p=0", fe_cnt - fe0, buffer_data_present);
        end
        send_byte(8'h12);
        total++;
        if (buffer_data_present !== 1'b1 || data_out !== 8'h12) begin
            bad++;
            $display("FAIL framing_then_12: got p=%b data=%h want p=1 data=12", buffer_data_present, data_out);
        end
        pop_one();
        total++;
        if (buffer_data_present !== 1'b0 || fe_cnt - fe0 !== 1) begin
            bad++;
            $display("FAIL framing_only_12: got p=%b pulses=%0d want p=0 pulses=1", buffer_data_present, fe_cnt - fe0);
        end
    endtask

    task automatic test_fill_overrun();
        int ov0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            total++;
            if (buffer_half_full !== (i >= 7) || buffer_full !== (i == 15)) begin
                bad++;
                $display("FAIL fill_flags[%0d]: got h=%b f=%b want h=%b f=%b",
                         i, buffer_half_full, buffer_full, (i >= 7), (i == 15));
            end
        end
        ov0 = ov_cnt;
        send_byte(8'h55);
        total++;
        if (ov_cnt - ov0 !== 1 || data_out !== 8'h00 || buffer_full !== 1'b1) begin
            bad++;
            $display("FAIL overrun_17th: got pulses=%0d head=%h f=%b want pulses=1 head=00 f=1",
                     ov_cnt - ov0, data_out, buffer_full);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (data_out !== 8'(i)) begin
                bad++;
                $display("FAIL fill_read[%0d]: got %h want %h", i, data_out, 8'(i));
            end
            pop_one();
        end
        total++;
        if (buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL fill_drained: got p=%b want 0", buffer_data_present);
        end
    endtask

    task automatic test_full_push_pop();
        int ov0;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        ov0 = ov_cnt;
        send_frame(8'h99, 16, 1'b1, PUSH_CYC, -1);
        idle(2);
        total++;
        if (ov_cnt - ov0 !== 0 || buffer_full !== 1'b1 || data_out !== 8'h21) begin
            bad++;
            $display("FAIL full_push_pop: got pulses=%0d f=%b head=%h want pulses=0 f=1 head=21",
                     ov_cnt - ov0, buffer_full, data_out);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'h21 + 8'(i) : 8'h99;
            total++;
            if (data_out !== exp) begin
                bad++;
                $display("FAIL full_pp_read[%0d]: got %h want %h", i, data_out, exp);
            end
            pop_one();
        end
    endtask

    task automatic test_one_push_pop();
        send_byte(8'h44);
        send_frame(8'h45, 16, 1'b1, PUSH_CYC, -1);
        idle(2);
        total++;
        if (buffer_data_present !== 1'b1 || data_out !== 8'h45) begin
            bad++;
            $display("FAIL one_push_pop: got p=%b data=%h want p=1 data=45", buffer_data_present, data_out);
        end
        pop_one();
        total++;
        if (buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL one_push_pop_count: got p=%b want 0", buffer_data_present);
        end
    endtask

    task automatic test_reset_buffer();
        int ov0;
        send_byte(8'h66);
        ov0 = ov_cnt;
        send_frame(8'h77, 16, 1'b1, -1, PUSH_CYC);
        idle(2);
        total++;
        if (buffer_data_present !== 1'b0 || ov_cnt - ov0 !== 0) begin
            bad++;
            $display("FAIL reset_buffer_push: got p=%b pulses=%0d want p=0 pulses=0",
                     buffer_data_present, ov_cnt - ov0);
        end
    endtask

    task automatic test_rst_midframe();
        send_byte(8'h5A);
        align();
        serial_in = 1'b0;
        repeat (224) step();
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        serial_in = 1'b1;
        total++;
        if (buffer_data_present !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_flush: got p=%b data=%h want p=0 data=00", buffer_data_present, data_out);
        end
        idle(30);
        send_byte(8'h81);
        total++;
        if (buffer_data_present !== 1'b1 || data_out !== 8'h81) begin
            bad++;
            $display("FAIL rst_then_81: got p=%b data=%h want p=1 data=81", buffer_data_present, data_out);
        end
        pop_one();
        total++;
        if (buffer_data_present !== 1'b0) begin
            bad++;
            $display("FAIL rst_only_81: got p=%b want 0", buffer_data_present);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_fill_overrun();
        test_full_push_pop();
        test_one_push_pop();
        test_reset_buffer();
        test_rst_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
